axi_mem_slave: RTL and testbench



---
 rtl/axi_mem_if.sv | 57 +++++
 rtl/axi_mem_slave.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_if.sv
// AXI4 memory-port bundle (no IDs, 32-bit data) between a master and axi_mem_slave.
// A transfer occurs on a CLK edge where VALID and READY are both 1; a source holds VALID and payload stable until then.
interface axi_mem_if #(
    parameter int C_OFFSET_WIDTH = 28
);
    logic [C_OFFSET_WIDTH-1:0] S_AXI_AWADDR;
    logic [7:0]                S_AXI_AWLEN;
    logic [2:0]                S_AXI_AWSIZE;
    logic [1:0]                S_AXI_AWBURST;
    logic                      S_AXI_AWVALID;
    logic                      S_AXI_AWREADY;
    logic [31:0]               S_AXI_WDATA;
    logic [3:0]                S_AXI_WSTRB;
    logic                      S_AXI_WLAST;
    logic                      S_AXI_WVALID;
    logic                      S_AXI_WREADY;
    logic [1:0]                S_AXI_BRESP;
    logic                      S_AXI_BVALID;
    logic                      S_AXI_BREADY;
    logic [C_OFFSET_WIDTH-1:0] S_AXI_ARADDR;
    logic [7:0]                S_AXI_ARLEN;
    logic [2:0]                S_AXI_ARSIZE;
    logic [1:0]                S_AXI_ARBURST;
    logic                      S_AXI_ARVALID;
    logic                      S_AXI_ARREADY;
    logic [31:0]               S_AXI_RDATA;
    logic [1:0]                S_AXI_RRESP;
    logic                      S_AXI_RLAST;
    logic                      S_AXI_RVALID;
    logic                      S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI4 word-addressed RAM responder with independent write and read burst FSMs (INCR/FIXED, SLVERR on WRAP/size/range).
// Optional macro AXI_MEM_RDLAT_EN inserts C_RD_LATENCY wait cycles before the first read beat.
module axi_mem_slave #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_OFFSET_WIDTH   = 28,
    parameter int C_MEM_WORDS      = 2048,
    parameter int C_RD_LATENCY     = 4
) (
    input  logic       CLK,
    input  logic       RSTN,
    axi_mem_if.slave   s_axi,
    output logic [1:0] wr_state_o,
    output logic [1:0] rd_state_o
);
    localparam int              WA_W        = C_OFFSET_WIDTH - 2;
    localparam int              IDX_W       = $clog2(C_MEM_WORDS);
    localparam logic [WA_W-1:0] MEM_WORDS_W = WA_W'(C_MEM_WORDS);
    localparam logic [1:0]      RESP_OKAY   = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;
    localparam logic [1:0]      BURST_FIXED = 2'b00;
    localparam logic [1:0]      BURST_INCR  = 2'b01;
    localparam logic [2:0]      SIZE_WORD   = 3'b010;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_BURST = 2'd2
`ifdef AXI_MEM_RDLAT_EN
        , R_WAIT = 2'd3
`endif
    } r_state_e;

    logic [C_AXI_DATA_WIDTH-1:0] mem_q [C_MEM_WORDS];

    // ---------------- write channel ----------------
    w_state_e        w_state_q, w_state_d;
    logic [WA_W-1:0] waddr_q, waddr_d;
    logic [7:0]      wlen_q, wlen_d;
    logic [7:0]      wcnt_q, wcnt_d;
    logic            winc_q, winc_d;
    logic            wreq_err_q, wreq_err_d;
    logic            wslverr_q, wslverr_d;

    logic       awready, wready, bvalid;
    logic [1:0] bresp;
    logic       aw_hs, w_hs, b_hs, w_oor, w_last_cnt, w_end, mem_we;

    assign aw_hs      = s_axi.S_AXI_AWVALID && awready;
    assign w_hs       = s_axi.S_AXI_WVALID && wready;
    assign b_hs       = bvalid && s_axi.S_AXI_BREADY;
    assign w_oor      = (waddr_q >= MEM_WORDS_W);
    assign w_last_cnt = (wcnt_q == wlen_q);
    assign w_end      = s_axi.S_AXI_WLAST || w_last_cnt;
    assign mem_we     = RSTN && w_hs && !wreq_err_q && !w_oor;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            w_state_q <= W_IDLE;
        end else begin
            w_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs) w_state_d = W_DATA;
            W_DATA:  if (w_hs && w_end) w_state_d = W_RESP;
            W_RESP:  if (b_hs) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        awready = (w_state_q == W_IDLE);
        wready  = (w_state_q == W_DATA);
        bvalid  = (w_state_q == W_RESP);
        bresp   = (bvalid && wslverr_q) ? RESP_SLVERR : RESP_OKAY;
    end

    // Beat errors and a WLAST/counter disagreement both fold into one sticky SLVERR.
    always_comb begin
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wcnt_d     = wcnt_q;
        winc_d     = winc_q;
        wreq_err_d = wreq_err_q;
        wslverr_d  = wslverr_q;
        if (aw_hs) begin
            waddr_d    = s_axi.S_AXI_AWADDR[C_OFFSET_WIDTH-1:2];
            wlen_d     = s_axi.S_AXI_AWLEN;
            wcnt_d     = 8'd0;
            winc_d     = (s_axi.S_AXI_AWBURST == BURST_INCR);
            wreq_err_d = ((s_axi.S_AXI_AWBURST != BURST_INCR) && (s_axi.S_AXI_AWBURST != BURST_FIXED))
                         || (s_axi.S_AXI_AWSIZE != SIZE_WORD);
            wslverr_d  = 1'b0;
        end else if (w_hs) begin
            if (winc_q) waddr_d = waddr_q + WA_W'(1);
            wcnt_d    = wcnt_q + 8'd1;
            wslverr_d = wslverr_q || wreq_err_q || w_oor || (s_axi.S_AXI_WLAST != w_last_cnt);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            waddr_q    <= '0;
            wlen_q     <= 8'd0;
            wcnt_q     <= 8'd0;
            winc_q     <= 1'b0;
            wreq_err_q <= 1'b0;
            wslverr_q  <= 1'b0;
        end else begin
            waddr_q    <= waddr_d;
            wlen_q     <= wlen_d;
            wcnt_q     <= wcnt_d;
            winc_q     <= winc_d;
            wreq_err_q <= wreq_err_d;
            wslverr_q  <= wslverr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi.S_AXI_WSTRB[b]) begin
                    mem_q[waddr_q[IDX_W-1:0]][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_e        r_state_q, r_state_d;
    logic [WA_W-1:0] raddr_q, raddr_d;
    logic [7:0]      rlen_q, rlen_d;
    logic            rinc_q, rinc_d;
    logic            rreq_err_q, rreq_err_d;
    logic [7:0]      iss_cnt_q, iss_cnt_d;
    logic            iss_done_q, iss_done_d;
    logic            pf_vld_q, pf_vld_d;
    logic [31:0]     pf_data_q, pf_data_d;
    logic            pf_err_q, pf_err_d;
    logic            pf_last_q, pf_last_d;
    logic            rvalid_q, rvalid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [1:0]      rresp_q, rresp_d;
    logic            rlast_q, rlast_d;

    logic arready, ar_hs, r_hs, pf_adv, issue;

    assign ar_hs  = s_axi.S_AXI_ARVALID && arready;
    assign r_hs   = rvalid_q && s_axi.S_AXI_RREADY;
    assign pf_adv = pf_vld_q && (!rvalid_q || s_axi.S_AXI_RREADY);
    // RAM is read only when the prefetch slot is free or drains into the output stage this cycle.
    assign issue  = (r_state_q == R_FETCH)
                    || ((r_state_q == R_BURST) && !iss_done_q && (!pf_vld_q || pf_adv));

`ifdef AXI_MEM_RDLAT_EN
    localparam logic [7:0] LAT_LAST = 8'(C_RD_LATENCY - 1);
    logic [7:0] lat_cnt_q, lat_cnt_d;

    always_comb begin
        lat_cnt_d = lat_cnt_q;
        if (ar_hs) lat_cnt_d = 8'd0;
        else if (r_state_q == R_WAIT) lat_cnt_d = lat_cnt_q + 8'd1;
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) lat_cnt_q <= 8'd0;
        else       lat_cnt_q <= lat_cnt_d;
    end
`else
    localparam int unused_rd_latency = C_RD_LATENCY;
`endif

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state_q <= R_IDLE;
        end else begin
            r_state_q <= r_state_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
`ifdef AXI_MEM_RDLAT_EN
            R_IDLE:  if (ar_hs) r_state_d = R_WAIT;
            R_WAIT:  if (lat_cnt_q == LAT_LAST) r_state_d = R_FETCH;
`else
            R_IDLE:  if (ar_hs) r_state_d = R_FETCH;
`endif
            R_FETCH: r_state_d = R_BURST;
            R_BURST: if (r_hs && rlast_q) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        arready = (r_state_q == R_IDLE);
    end

    always_comb begin
        raddr_d    = raddr_q;
        rlen_d     = rlen_q;
        rinc_d     = rinc_q;
        rreq_err_d = rreq_err_q;
        iss_cnt_d  = iss_cnt_q;
        iss_done_d = iss_done_q;
        pf_vld_d   = pf_vld_q;
        pf_data_d  = pf_data_q;
        pf_err_d   = pf_err_q;
        pf_last_d  = pf_last_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        if (ar_hs) begin
            raddr_d    = s_axi.S_AXI_ARADDR[C_OFFSET_WIDTH-1:2];
            rlen_d     = s_axi.S_AXI_ARLEN;
            rinc_d     = (s_axi.S_AXI_ARBURST == BURST_INCR);
            rreq_err_d = ((s_axi.S_AXI_ARBURST != BURST_INCR) && (s_axi.S_AXI_ARBURST != BURST_FIXED))
                         || (s_axi.S_AXI_ARSIZE != SIZE_WORD);
            iss_cnt_d  = 8'd0;
            iss_done_d = 1'b0;
        end
        if (issue) begin
            pf_vld_d   = 1'b1;
            pf_data_d  = mem_q[raddr_q[IDX_W-1:0]];
            pf_err_d   = rreq_err_q || (raddr_q >= MEM_WORDS_W);
            pf_last_d  = (iss_cnt_q == rlen_q);
            iss_cnt_d  = iss_cnt_q + 8'd1;
            iss_done_d = (iss_cnt_q == rlen_q);
            if (rinc_q) raddr_d = raddr_q + WA_W'(1);
        end else if (pf_adv) begin
            pf_vld_d = 1'b0;
        end
        if (pf_adv) begin
            rvalid_d = 1'b1;
            rdata_d  = pf_err_q ? 32'd0 : pf_data_q;
            rresp_d  = pf_err_q ? RESP_SLVERR : RESP_OKAY;
            rlast_d  = pf_last_q;
        end else if (r_hs) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            raddr_q    <= '0;
            rlen_q     <= 8'd0;
            rinc_q     <= 1'b0;
            rreq_err_q <= 1'b0;
            iss_cnt_q  <= 8'd0;
            iss_done_q <= 1'b0;
            pf_vld_q   <= 1'b0;
            pf_data_q  <= 32'd0;
            pf_err_q   <= 1'b0;
            pf_last_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'd0;
            rresp_q    <= RESP_OKAY;
            rlast_q    <= 1'b0;
        end else begin
            raddr_q    <= raddr_d;
            rlen_q     <= rlen_d;
            rinc_q     <= rinc_d;
            rreq_err_q <= rreq_err_d;
            iss_cnt_q  <= iss_cnt_d;
            iss_done_q <= iss_done_d;
            pf_vld_q   <= pf_vld_d;
            pf_data_q  <= pf_data_d;
            pf_err_q   <= pf_err_d;
            pf_last_q  <= pf_last_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
        end
    end

    // ---------------- port drive ----------------
    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_BVALID  = bvalid;
    assign s_axi.S_AXI_BRESP   = bresp;
    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign s_axi.S_AXI_RLAST   = rlast_q;

    assign wr_state_o = w_state_q;
    assign rd_state_o = r_state_q;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: bursts, strobes, stalls, boundaries, error responses and reset.
module tb_axi_mem_slave;
  localparam int MEM_WORDS = 2048;
  localparam int RD_LAT    = 4;
`ifdef AXI_MEM_RDLAT_EN
  localparam int EXP_LAT = 2 + RD_LAT;
`else
  localparam int EXP_LAT = 2;
`endif
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi_mem_if bus ();
  logic [1:0] wr_state, rd_state;

  axi_mem_slave #(
    .C_AXI_DATA_WIDTH(32), .C_OFFSET_WIDTH(28), .C_MEM_WORDS(MEM_WORDS), .C_RD_LATENCY(RD_LAT)
  ) dut (
    .CLK(clk), .RSTN(rstn), .s_axi(bus), .wr_state_o(wr_state), .rd_state_o(rd_state)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] wbuf [16];
  logic [31:0] rbuf [16];
  logic [1:0]  rrbuf [16];
  logic        rlbuf [16];
  int          first_lat;
  int          span;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic init_inputs();
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = 8'd0; bus.S_AXI_AWSIZE = 3'b010;
    bus.S_AXI_AWBURST = INCR; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = 32'd0; bus.S_AXI_WSTRB = 4'h0; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = 8'd0; bus.S_AXI_ARSIZE = 3'b010;
    bus.S_AXI_ARBURST = INCR; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic axi_write(input logic [27:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] strb, input int nbeats, output logic [1:0] resp);
    int n;
    bus.S_AXI_AWADDR = addr; bus.S_AXI_AWLEN = len; bus.S_AXI_AWSIZE = 3'b010;
    bus.S_AXI_AWBURST = burst; bus.S_AXI_AWVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_AWREADY && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin vec_cnt++; err_cnt++; $display("FAIL aw_timeout: AWREADY=0 required 1"); end
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      bus.S_AXI_WDATA = wbuf[i]; bus.S_AXI_WSTRB = strb;
      bus.S_AXI_WLAST = (i == nbeats - 1); bus.S_AXI_WVALID = 1'b1;
      n = 0;
      while (!bus.S_AXI_WREADY && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) begin vec_cnt++; err_cnt++; $display("FAIL w_timeout beat %0d: WREADY=0 required 1", i); end
      @(posedge clk); #1;
    end
    bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    n = 0;
    while (!bus.S_AXI_BVALID && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin vec_cnt++; err_cnt++; $display("FAIL b_timeout: BVALID=0 required 1"); end
    resp = bus.S_AXI_BRESP;
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b0;
  endtask

  // mode 0: RREADY always 1; mode 1: RREADY pattern 1,0,0 repeating over valid cycles.
  task automatic axi_read(input logic [27:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input int mode);
    int n, k, nb, pat, last_k;
    logic held, hl;
    logic [31:0] hd;
    logic [1:0] hr;
    bus.S_AXI_ARADDR = addr; bus.S_AXI_ARLEN = len; bus.S_AXI_ARSIZE = 3'b010;
    bus.S_AXI_ARBURST = burst; bus.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin vec_cnt++; err_cnt++; $display("FAIL ar_timeout: ARREADY=0 required 1"); end
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    k = 0; nb = 0; pat = 0; held = 1'b0; first_lat = -1; last_k = 0;
    hd = 32'd0; hr = 2'd0; hl = 1'b0;
    while (nb <= int'(len) && k < 200) begin
      @(posedge clk); #1; k++;
      if (held) begin
        vec_cnt++;
        if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== hd || bus.S_AXI_RRESP !== hr
            || bus.S_AXI_RLAST !== hl) begin
          err_cnt++;
          $display("FAIL r_stall_hold beat %0d: got v=%b d=%h r=%h l=%b, required v=1 d=%h r=%h l=%b",
                   nb, bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.S_AXI_RRESP, bus.S_AXI_RLAST, hd, hr, hl);
        end
      end
      if (bus.S_AXI_RVALID === 1'b1 && first_lat < 0) first_lat = k;
      bus.S_AXI_RREADY = (mode == 0) ? 1'b1 : ((pat % 3) == 0);
      if (bus.S_AXI_RVALID === 1'b1) begin
        pat++;
        if (bus.S_AXI_RREADY) begin
          rbuf[nb] = bus.S_AXI_RDATA; rrbuf[nb] = bus.S_AXI_RRESP; rlbuf[nb] = bus.S_AXI_RLAST;
          nb++; last_k = k; held = 1'b0;
        end else begin
          held = 1'b1; hd = bus.S_AXI_RDATA; hr = bus.S_AXI_RRESP; hl = bus.S_AXI_RLAST;
        end
      end else begin
        held = 1'b0;
      end
    end
    if (nb <= int'(len)) begin
      vec_cnt++; err_cnt++;
      $display("FAIL r_timeout: got %0d beats, required %0d", nb, int'(len) + 1);
    end
    span = last_k - first_lat + 1;
    @(posedge clk); #1;
    bus.S_AXI_RREADY = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++; if (bus.S_AXI_AWREADY !== 1'b1) begin err_cnt++; $display("FAIL rst_awready: got %b required 1", bus.S_AXI_AWREADY); end
    vec_cnt++; if (bus.S_AXI_ARREADY !== 1'b1) begin err_cnt++; $display("FAIL rst_arready: got %b required 1", bus.S_AXI_ARREADY); end
    vec_cnt++; if (bus.S_AXI_WREADY !== 1'b0) begin err_cnt++; $display("FAIL rst_wready: got %b required 0", bus.S_AXI_WREADY); end
    vec_cnt++; if (bus.S_AXI_BVALID !== 1'b0) begin err_cnt++; $display("FAIL rst_bvalid: got %b required 0", bus.S_AXI_BVALID); end
    vec_cnt++; if (bus.S_AXI_RVALID !== 1'b0) begin err_cnt++; $display("FAIL rst_rvalid: got %b required 0", bus.S_AXI_RVALID); end
    vec_cnt++; if (bus.S_AXI_RLAST !== 1'b0) begin err_cnt++; $display("FAIL rst_rlast: got %b required 0", bus.S_AXI_RLAST); end
    vec_cnt++; if (bus.S_AXI_BRESP !== 2'b00) begin err_cnt++; $display("FAIL rst_bresp: got %b required 00", bus.S_AXI_BRESP); end
    vec_cnt++; if (bus.S_AXI_RRESP !== 2'b00) begin err_cnt++; $display("FAIL rst_rresp: got %b required 00", bus.S_AXI_RRESP); end
    vec_cnt++; if (bus.S_AXI_RDATA !== 32'd0) begin err_cnt++; $display("FAIL rst_rdata: got %h required 0", bus.S_AXI_RDATA); end
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++;
    if (bus.S_AXI_AWREADY !== 1'b1 || bus.S_AXI_ARREADY !== 1'b1 || bus.S_AXI_RVALID !== 1'b0) begin
      err_cnt++;
      $display("FAIL idle_after_reset: got aw=%b ar=%b rv=%b required 1 1 0",
               bus.S_AXI_AWREADY, bus.S_AXI_ARREADY, bus.S_AXI_RVALID);
    end
  endtask

  task automatic test_incr_burst();
    logic [1:0] resp;
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
    axi_write(28'h10, 8'd3, INCR, 4'hF, 4, resp);
    vec_cnt++; if (resp !== OKAY) begin err_cnt++; $display("FAIL incr_bresp: got %b required 00", resp); end
    vec_cnt++;
    if (bus.S_AXI_BVALID !== 1'b0 || bus.S_AXI_AWREADY !== 1'b1) begin
      err_cnt++; $display("FAIL incr_b_once: got bvalid=%b awready=%b required 0 1", bus.S_AXI_BVALID, bus.S_AXI_AWREADY);
    end
    axi_read(28'h10, 8'd3, INCR, 0);
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (rbuf[i] !== 32'hA0 + i || rrbuf[i] !== OKAY || rlbuf[i] !== (i == 3)) begin
        err_cnt++;
        $display("FAIL incr_rbeat %0d: got d=%h r=%b l=%b required d=%h r=00 l=%b", i, rbuf[i], rrbuf[i], rlbuf[i], 32'hA0 + i, i == 3);
      end
    end
    vec_cnt++; if (first_lat != EXP_LAT) begin err_cnt++; $display("FAIL incr_first_latency: got %0d required %0d", first_lat, EXP_LAT); end
    vec_cnt++; if (span != 4) begin err_cnt++; $display("FAIL incr_span: got %0d required 4", span); end
    vec_cnt++;
    if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_ARREADY !== 1'b1) begin
      err_cnt++; $display("FAIL incr_r_end: got rvalid=%b arready=%b required 0 1", bus.S_AXI_RVALID, bus.S_AXI_ARREADY);
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp;
    wbuf[0] = 32'h11223344;
    axi_write(28'h0, 8'd0, INCR, 4'hF, 1, resp);
    wbuf[0] = 32'h0000AB00;
    axi_write(28'h0, 8'd0, INCR, 4'b0010, 1, resp);
    vec_cnt++; if (resp !== OKAY) begin err_cnt++; $display("FAIL strb_bresp: got %b required 00", resp); end
    axi_read(28'h0, 8'd0, INCR, 0);
    vec_cnt++;
    if (rbuf[0] !== 32'h1122AB44 || rlbuf[0] !== 1'b1) begin
      err_cnt++; $display("FAIL strb_rdata: got %h l=%b required 1122ab44 l=1", rbuf[0], rlbuf[0]);
    end
  endtask

  task automatic test_rready_toggle();
    logic [1:0] resp;
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hC0 + i;
    axi_write(28'h100, 8'd7, INCR, 4'hF, 8, resp);
    vec_cnt++; if (resp !== OKAY) begin err_cnt++; $display("FAIL tog_bresp: got %b required 00", resp); end
    axi_read(28'h100, 8'd7, INCR, 1);
    for (int i = 0; i < 8; i++) begin
      vec_cnt++;
      if (rbuf[i] !== 32'hC0 + i || rrbuf[i] !== OKAY || rlbuf[i] !== (i == 7)) begin
        err_cnt++;
        $display("FAIL tog_rbeat %0d: got d=%h r=%b l=%b required d=%h r=00 l=%b", i, rbuf[i], rrbuf[i], rlbuf[i], 32'hC0 + i, i == 7);
      end
    end
    axi_read(28'h100, 8'd7, INCR, 0);
    vec_cnt++; if (span != 8) begin err_cnt++; $display("FAIL stream_span: got %0d required 8", span); end
    vec_cnt++; if (rbuf[7] !== 32'hC7 || rlbuf[7] !== 1'b1) begin err_cnt++; $display("FAIL stream_last: got %h l=%b required c7 l=1", rbuf[7], rlbuf[7]); end
  endtask

  task automatic test_fixed();
    logic [1:0] resp;
    wbuf[0] = 32'h55;
    axi_write(28'h44, 8'd0, INCR, 4'hF, 1, resp);
    wbuf[0] = 32'hD0; wbuf[1] = 32'hD1; wbuf[2] = 32'hD2;
    axi_write(28'h40, 8'd2, FIXED, 4'hF, 3, resp);
    vec_cnt++; if (resp !== OKAY) begin err_cnt++; $display("FAIL fixed_bresp: got %b required 00", resp); end
    axi_read(28'h40, 8'd2, FIXED, 0);
    for (int i = 0; i < 3; i++) begin
      vec_cnt++;
      if (rbuf[i] !== 32'hD2 || rrbuf[i] !== OKAY) begin
        err_cnt++; $display("FAIL fixed_rbeat %0d: got %h r=%b required d2 r=00", i, rbuf[i], rrbuf[i]);
      end
    end
    axi_read(28'h44, 8'd0, INCR, 0);
    vec_cnt++; if (rbuf[0] !== 32'h55) begin err_cnt++; $display("FAIL fixed_neighbour: got %h required 55", rbuf[0]); end
  endtask

  task automatic test_boundary();
    logic [1:0] resp;
    logic [27:0] top_addr;
    top_addr = 28'(4 * MEM_WORDS - 4);
    wbuf[0] = 32'hDEADBEEF;
    axi_write(top_addr, 8'd0, INCR, 4'hF, 1, resp);
    vec_cnt++; if (resp !== OKAY) begin err_cnt++; $display("FAIL top_bresp: got %b required 00", resp); end
    axi_read(top_addr, 8'd1, INCR, 0);
    vec_cnt++;
    if (rbuf[0] !== 32'hDEADBEEF || rrbuf[0] !== OKAY || rlbuf[0] !== 1'b0) begin
      err_cnt++; $display("FAIL top_beat0: got d=%h r=%b l=%b required deadbeef 00 0", rbuf[0], rrbuf[0], rlbuf[0]);
    end
    vec_cnt++;
    if (rbuf[1] !== 32'd0 || rrbuf[1] !== SLVERR || rlbuf[1] !== 1'b1) begin
      err_cnt++; $display("FAIL top_beat1_oor: got d=%h r=%b l=%b required 0 10 1", rbuf[1], rrbuf[1], rlbuf[1]);
    end
    wbuf[0] = 32'h12345678; wbuf[1] = 32'h9;
    axi_write(top_addr, 8'd1, INCR, 4'hF, 2, resp);
    vec_cnt++; if (resp !== SLVERR) begin err_cnt++; $display("FAIL oor_write_bresp: got %b required 10", resp); end
    axi_read(top_addr, 8'd0, INCR, 0);
    vec_cnt++; if (rbuf[0] !== 32'h12345678) begin err_cnt++; $display("FAIL oor_write_beat0: got %h required 12345678", rbuf[0]); end
    axi_read(28'(4 * MEM_WORDS), 8'd0, INCR, 0);
    vec_cnt++;
    if (rbuf[0] !== 32'd0 || rrbuf[0] !== SLVERR) begin
      err_cnt++; $display("FAIL oor_read: got d=%h r=%b required 0 10", rbuf[0], rrbuf[0]);
    end
  endtask

  task automatic test_errors();
    logic [1:0] resp;
    wbuf[0] = 32'hFFFFFFFF;
    axi_write(28'h10, 8'd0, WRAP, 4'hF, 1, resp);
    vec_cnt++; if (resp !== SLVERR) begin err_cnt++; $display("FAIL wrap_bresp: got %b required 10", resp); end
    axi_read(28'h10, 8'd0, INCR, 0);
    vec_cnt++; if (rbuf[0] !== 32'hA0) begin err_cnt++; $display("FAIL wrap_no_write: got %h required a0", rbuf[0]); end
    axi_read(28'h10, 8'd1, WRAP, 0);
    for (int i = 0; i < 2; i++) begin
      vec_cnt++;
      if (rbuf[i] !== 32'd0 || rrbuf[i] !== SLVERR || rlbuf[i] !== (i == 1)) begin
        err_cnt++; $display("FAIL wrap_rbeat %0d: got d=%h r=%b l=%b required 0 10 %b", i, rbuf[i], rrbuf[i], rlbuf[i], i == 1);
      end
    end
    wbuf[0] = 32'h77;
    axi_write(28'h200, 8'd1, INCR, 4'hF, 1, resp);
    vec_cnt++; if (resp !== SLVERR) begin err_cnt++; $display("FAIL early_wlast_bresp: got %b required 10", resp); end
    vec_cnt++; if (bus.S_AXI_AWREADY !== 1'b1) begin err_cnt++; $display("FAIL early_wlast_idle: got %b required 1", bus.S_AXI_AWREADY); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp;
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hB0 + i;
    fork
      axi_write(28'h300, 8'd3, INCR, 4'hF, 4, resp);
      axi_read(28'h100, 8'd3, INCR, 0);
    join
    vec_cnt++; if (resp !== OKAY) begin err_cnt++; $display("FAIL b2b_bresp: got %b required 00", resp); end
    for (int i = 0; i < 4; i++) begin
      vec_cnt++; if (rbuf[i] !== 32'hC0 + i) begin err_cnt++; $display("FAIL b2b_rbeat %0d: got %h required %h", i, rbuf[i], 32'hC0 + i); end
    end
    axi_read(28'h300, 8'd3, INCR, 0);
    for (int i = 0; i < 4; i++) begin
      vec_cnt++; if (rbuf[i] !== 32'hB0 + i) begin err_cnt++; $display("FAIL b2b_readback %0d: got %h required %h", i, rbuf[i], 32'hB0 + i); end
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    bus.S_AXI_ARADDR = 28'h100; bus.S_AXI_ARLEN = 8'd7; bus.S_AXI_ARSIZE = 3'b010;
    bus.S_AXI_ARBURST = INCR; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b0;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    n = 0;
    while (bus.S_AXI_RVALID !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    vec_cnt++; if (bus.S_AXI_RVALID !== 1'b1) begin err_cnt++; $display("FAIL midrst_rvalid_seen: got %b required 1", bus.S_AXI_RVALID); end
    rstn = 1'b0;
    @(posedge clk); #1;
    vec_cnt++;
    if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_RLAST !== 1'b0 || bus.S_AXI_ARREADY !== 1'b1) begin
      err_cnt++; $display("FAIL midrst_abandon: got rv=%b rl=%b ar=%b required 0 0 1",
                          bus.S_AXI_RVALID, bus.S_AXI_RLAST, bus.S_AXI_ARREADY);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    vec_cnt++; if (bus.S_AXI_RVALID !== 1'b0) begin err_cnt++; $display("FAIL midrst_no_beats: got %b required 0", bus.S_AXI_RVALID); end
    axi_read(28'h100, 8'd0, INCR, 0);
    vec_cnt++; if (rbuf[0] !== 32'hC0) begin err_cnt++; $display("FAIL midrst_ram_kept: got %h required c0", rbuf[0]); end
    vec_cnt++; if (first_lat != EXP_LAT) begin err_cnt++; $display("FAIL midrst_latency: got %0d required %0d", first_lat, EXP_LAT); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    init_inputs();
    test_reset();
    test_incr_burst();
    test_strobe();
    test_rready_toggle();
    test_fixed();
    test_boundary();
    test_errors();
    test_back_to_back();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
